// File: rtl/dog_anim_pkg.sv
// dog_anim_pkg: shared animation modes, per-mode frame ranges and palette defaults for the dog sprite
package dog_anim_pkg;
  typedef enum logic [1:0] {
    MODE_WALK  = 2'd0,
    MODE_SNIFF = 2'd1,
    MODE_JUMP  = 2'd2,
    MODE_IDLE  = 2'd3
  } dog_mode_e;
  localparam logic [4:0] WALK_FIRST  = 5'd0;
  localparam logic [4:0] WALK_LAST   = 5'd3;
  localparam logic [4:0] SNIFF_FIRST = 5'd4;
  localparam logic [4:0] SNIFF_LAST  = 5'd5;
  localparam logic [4:0] JUMP_FIRST  = 5'd6;
  localparam logic [4:0] JUMP_LAST   = 5'd8;
  localparam logic [4:0] IDLE_FRAME  = 5'd0;
  localparam logic [3:0] TRANSPARENT_DEFAULT = 4'h0;
  function automatic logic [4:0] first_frame(input dog_mode_e m);
    return m == MODE_WALK ? WALK_FIRST : m == MODE_SNIFF ? SNIFF_FIRST : m == MODE_JUMP ? JUMP_FIRST : IDLE_FRAME;
  endfunction
endpackage

// File: rtl/dog_anim_seq.sv
// dog_anim_seq: per-mode animation frame sequencer advancing on frame_tick with a hold counter
module dog_anim_seq
  import dog_anim_pkg::*;
#(
  parameter int HOLD_TICKS = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] mode,
  output logic [4:0] frame,
  output logic       jump_done
);
  localparam logic [2:0] HOLD_LAST = 3'(HOLD_TICKS - 1);
  dog_mode_e  mode_q, mode_d, mode_in;
  logic [2:0] hold_q, hold_d;
  logic [4:0] frame_q, frame_d, next_frame;
  logic       jump_done_q, jump_done_d, wrap;
  assign mode_in = dog_mode_e'(mode);
  assign wrap = hold_q == HOLD_LAST;
  assign next_frame = mode_q == MODE_WALK  ? (frame_q == WALK_LAST ? WALK_FIRST : frame_q + 5'd1) :
                      mode_q == MODE_SNIFF ? (frame_q == SNIFF_FIRST ? SNIFF_LAST : SNIFF_FIRST) :
                      mode_q == MODE_JUMP  ? (frame_q == JUMP_LAST ? JUMP_LAST : frame_q + 5'd1) :
                      IDLE_FRAME;
  always_comb begin
    mode_d = mode_q;
    hold_d = hold_q;
    frame_d = frame_q;
    jump_done_d = 1'b0;
    if (frame_tick && mode_in != mode_q) begin
      mode_d = mode_in;
      hold_d = 3'd0;
      frame_d = first_frame(mode_in);
    end else if (frame_tick) begin
      hold_d = wrap ? 3'd0 : hold_q + 3'd1;
      frame_d = wrap ? next_frame : frame_q;
      jump_done_d = wrap && mode_q == MODE_JUMP && frame_q == JUMP_LAST - 5'd1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_IDLE;
      hold_q <= 3'd0;
      frame_q <= IDLE_FRAME;
      jump_done_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      hold_q <= hold_d;
      frame_q <= frame_d;
      jump_done_q <= jump_done_d;
    end
  end
  assign frame = frame_q;
  assign jump_done = jump_done_q;
endmodule

// File: rtl/dog_sprite_reader.sv
// dog_sprite_reader: two-stage sprite address/pixel pipeline plus animation frame selection
module dog_sprite_reader
  import dog_anim_pkg::*;
#(
  parameter int         HOLD_TICKS  = 6,
  parameter logic [3:0] TRANSPARENT = TRANSPARENT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [1:0]  mode,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  DogX,
  input  logic [9:0]  DogY,
  input  logic [6:0]  DogSizeX,
  input  logic [6:0]  DogSizeY,
  input  logic [3:0]  q,
  output logic [4:0]  frame,
  output logic [13:0] address,
  output logic        pixel_on,
  output logic [3:0]  pixel_index,
  output logic        jump_done
);
  logic [9:0]  dx, dy;
  logic [13:0] address_q, address_d;
  logic        in_sprite, in_sprite_q, pixel_on_q;
  logic [3:0]  pixel_index_q;
  dog_anim_seq #(.HOLD_TICKS(HOLD_TICKS)) u_seq (
    .clock(clock),
    .reset(reset),
    .frame_tick(frame_tick),
    .mode(mode),
    .frame(frame),
    .jump_done(jump_done)
  );
  assign dx = DrawX - DogX;
  assign dy = DrawY - DogY;
  // ordering checks guard against the 10-bit differences wrapping; zero sizes never match
  assign in_sprite = DrawX >= DogX && dx < {3'b0, DogSizeX} && DrawY >= DogY && dy < {3'b0, DogSizeY};
  assign address_d = in_sprite ? 14'(dy) * 14'(DogSizeX) + 14'(dx) : 14'd0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address_q <= 14'd0;
      in_sprite_q <= 1'b0;
      pixel_on_q <= 1'b0;
      pixel_index_q <= 4'd0;
    end else begin
      address_q <= address_d;
      in_sprite_q <= in_sprite;
      pixel_on_q <= in_sprite_q && q != TRANSPARENT;
      pixel_index_q <= in_sprite_q ? q : 4'd0;
    end
  end
  assign address = address_q;
  assign pixel_on = pixel_on_q;
  assign pixel_index = pixel_index_q;
endmodule
